operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Parametrised front-end that captures ALU operands and an opcode from board switches under push-button control.
- Replaces direct level-sensitive button loading with synchronised, debounced, edge-detected presses.
- Supports N operand channels and two load modes: direct (one button per register) and sequential (a single "next" button steps through registers).
- Presents the captured operand set to the ALU stage through a valid/ready handshake.

Parameters:
- NB_DATA, 8, operand and switch width; NB_OP must be <= NB_DATA.
- NB_OP, 6, opcode width.
- N_OPERANDS, 2, number of operand registers (>=1).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button level change (>=1).

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_buttons  in  N_OPERANDS+1  raw buttons; bit k<N_OPERANDS selects operand k, bit N_OPERANDS selects opcode. Sequential mode uses bit 0 only.
- i_switches  in  NB_DATA  value to capture.
- i_mode  in  1  0 = direct, 1 = sequential.
- i_ready  in  1  consumer accepts the operand set.
- o_operands  out  N_OPERANDS*NB_DATA  operand k at bits [k*NB_DATA +: NB_DATA].
- o_operation  out  NB_OP  captured opcode.
- o_valid  out  1  complete set available.
- o_loaded  out  N_OPERANDS+1  per-register "loaded since last transfer" flags.

Behaviour:

Reset:
- Operands, opcode, o_loaded, o_valid, sequence index, synchroniser and debounce state all go to 0.
- FSM goes to S_COLLECT.
- The registered i_mode copy takes the current i_mode.
- Reset mid-debounce or mid-sequence discards all progress.

Per-button conditioning:
- Two-FF synchroniser, then a debouncer with counter width clog2(DEBOUNCE_CYCLES), minimum 1 bit.
- The counter clears whenever the synchronised level equals the debounced level.
- Otherwise the counter increments. At the edge where count == DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level takes the new value and the counter clears.
- Press pulse = debounced & ~debounced_delayed.
  - Exactly one cycle per press, regardless of hold time.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Latency: if raw is high at edge 0, the pulse is high in the cycle after edge DEBOUNCE_CYCLES+1. The capture happens at the following edge.

Capture:
- Operand k <= i_switches.
- Opcode <= i_switches[NB_OP-1:0].
- The matching o_loaded bit is set.

FSM, S_COLLECT:
- Direct mode:
  - Every pulsing button captures at the same edge.
  - Simultaneous presses load the same switch value into each selected register.
  - Reloading an already-loaded register overwrites it.
- Sequential mode:
  - A bit-0 pulse captures into register idx: operands 0..N_OPERANDS-1, then the opcode at idx = N_OPERANDS.
  - idx then increments. Other buttons are ignored.
- When all o_loaded bits are 1 at an edge, go to S_VALID. o_valid rises one cycle after the final capture.

FSM, S_VALID:
- o_valid = 1. All presses are ignored and register values are stable.
- At an edge with i_ready = 1: go to S_COLLECT, clear o_loaded, set idx to 0, drop o_valid from the next cycle.
- Operand and opcode registers retain their values after transfer.

Mode change:
- A mismatch between i_mode and its registered copy clears o_loaded and idx, forces S_COLLECT (o_valid low next cycle), and updates the copy.
- Register contents are kept.
- Presses in that same cycle are discarded.

Test Plan (N_OPERANDS=2, NB_DATA=8, NB_OP=6, DEBOUNCE_CYCLES=4):
1. Reset: hold i_reset 3 cycles with buttons high and switches 0xFF -> all outputs 0. After release, buttons must first be debounced before any capture occurs.
2. Debounce:
   - Bit 0 high for 3 cycles with switches 0x5A -> no change.
   - Bit 0 high for 12 cycles -> operand0 = 0x5A captured exactly once, o_loaded = 3'b001, capture edge at DEBOUNCE_CYCLES+2 after the first high sample.
3. Direct handshake:
   - Load A = 0x12, B = 0x34, opcode from switches 0xE5 -> o_operation = 6'h25; o_valid rises one cycle after the opcode capture.
   - Hold i_ready = 0 for 5 cycles and press bit 0 with 0xFF -> operand0 stays 0x12.
   - Set i_ready = 1 -> o_valid low next cycle, o_loaded = 0, o_operands still 0x3412.
4. Sequential: i_mode = 1, three bit-0 presses with 0x01, 0x02, 0x03, plus bit-1 presses in between -> operand0 = 0x01, operand1 = 0x02, opcode = 0x03; bit-1 presses have no effect; o_valid set.
5. Mode switch: in sequential mode after one capture, toggle i_mode -> o_loaded = 0 and the next direct bit-1 press loads operand1. Also assert reset mid-debounce -> no capture.
6. Simultaneous: in direct mode, bits 0 and 1 pressed together with 0x77 -> both operands 0x77, o_loaded = 3'b011, o_valid stays low until the opcode is loaded.

Source files
------------

// File: rtl/operand_loader_if.sv
// Operand loader bus: raw board inputs in, captured operand set and handshake out.
interface operand_loader_if #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int N_OPERANDS = 2
);
  logic [N_OPERANDS:0]            i_buttons;
  logic [NB_DATA-1:0]             i_switches;
  logic                           i_mode;
  logic                           i_ready;
  logic [N_OPERANDS*NB_DATA-1:0]  o_operands;
  logic [NB_OP-1:0]               o_operation;
  logic                           o_valid;
  logic [N_OPERANDS:0]            o_loaded;

  modport master (
    output i_buttons, i_switches, i_mode, i_ready,
    input  o_operands, o_operation, o_valid, o_loaded
  );

  modport slave (
    input  i_buttons, i_switches, i_mode, i_ready,
    output o_operands, o_operation, o_valid, o_loaded
  );
endinterface

// File: rtl/operand_loader.sv
// Captures ALU operands and opcode from switches on debounced button presses,
// in direct or sequential mode, and hands the set over via valid/ready.
module operand_loader #(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int N_OPERANDS      = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  operand_loader_if.slave bus
);
  localparam int unsigned NBTN = N_OPERANDS + 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int IW = $clog2(N_OPERANDS + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_OPCODE = IW'(N_OPERANDS);

  typedef enum logic {S_COLLECT, S_VALID} state_t;

  state_t                              state_q, state_d;
  logic [NBTN-1:0]                     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NBTN-1:0]                     deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [NBTN-1:0][CW-1:0]             cnt_q, cnt_d;
  logic [N_OPERANDS-1:0][NB_DATA-1:0]  operands_q, operands_d;
  logic [NB_OP-1:0]                    operation_q, operation_d;
  logic [NBTN-1:0]                     loaded_q, loaded_d;
  logic [IW-1:0]                       idx_q, idx_d;
  logic                                mode_q, mode_d;

  logic [NBTN-1:0] pulse;
  logic            mode_change;
  logic            all_loaded;

  assign pulse       = deb_q & ~deb_dly_q;
  assign mode_change = bus.i_mode != mode_q;
  assign all_loaded  = &loaded_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_COLLECT;
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_dly_q   <= '0;
      cnt_q       <= '0;
      operands_q  <= '0;
      operation_q <= '0;
      loaded_q    <= '0;
      idx_q       <= '0;
      mode_q      <= bus.i_mode;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_dly_d;
      cnt_q       <= cnt_d;
      operands_q  <= operands_d;
      operation_q <= operation_d;
      loaded_q    <= loaded_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    sync1_d   = bus.i_buttons;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = cnt_q;
    for (int unsigned k = 0; k < NBTN; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        deb_d[k] = sync2_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_change) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT: if (all_loaded)  state_d = S_VALID;
        S_VALID:   if (bus.i_ready) state_d = S_COLLECT;
        default:                    state_d = S_COLLECT;
      endcase
    end
  end

  // Mode change outranks both the handshake and any press in the same cycle.
  always_comb begin
    operands_d  = operands_q;
    operation_d = operation_q;
    loaded_d    = loaded_q;
    idx_d       = idx_q;
    mode_d      = bus.i_mode;
    if (mode_change) begin
      loaded_d = '0;
      idx_d    = '0;
    end else if (state_q == S_VALID) begin
      if (bus.i_ready) begin
        loaded_d = '0;
        idx_d    = '0;
      end
    end else if (!mode_q) begin
      for (int unsigned k = 0; k < N_OPERANDS; k++) begin
        if (pulse[k]) begin
          operands_d[k] = bus.i_switches;
          loaded_d[k]   = 1'b1;
        end
      end
      if (pulse[N_OPERANDS]) begin
        operation_d          = bus.i_switches[NB_OP-1:0];
        loaded_d[N_OPERANDS] = 1'b1;
      end
    end else if (pulse[0] && idx_q <= IDX_OPCODE) begin
      for (int unsigned k = 0; k < N_OPERANDS; k++) begin
        if (idx_q == IW'(k)) begin
          operands_d[k] = bus.i_switches;
          loaded_d[k]   = 1'b1;
        end
      end
      if (idx_q == IDX_OPCODE) begin
        operation_d          = bus.i_switches[NB_OP-1:0];
        loaded_d[N_OPERANDS] = 1'b1;
      end
      idx_d = idx_q + 1'b1;
    end
  end

  always_comb begin
    bus.o_operands  = operands_q;
    bus.o_operation = operation_q;
    bus.o_valid     = (state_q == S_VALID);
    bus.o_loaded    = loaded_q;
  end
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: reset, debounce, direct/sequential loading,
// handshake, mode switch and simultaneous presses.
module tb_operand_loader;
  logic i_clock;
  logic i_reset;
  int   total;
  int   bad;

  operand_loader_if #(.NB_DATA(8), .NB_OP(6), .N_OPERANDS(2)) bus ();

  operand_loader #(
    .NB_DATA(8),
    .NB_OP(6),
    .N_OPERANDS(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .bus(bus)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  // Capture lands at the 7th rising edge after the press begins; return just after it.
  task automatic press(input logic [2:0] mask, input logic [7:0] sw);
    bus.i_switches = sw;
    bus.i_buttons  = mask;
    cyc(7);
  endtask

  task automatic release_btn();
    bus.i_buttons = '0;
    cyc(10);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    i_reset        = 1'b1;
    bus.i_buttons  = 3'b111;
    bus.i_switches = 8'hFF;
    bus.i_mode     = 1'b0;
    bus.i_ready    = 1'b0;

    // 1. reset
    cyc(3);
    check("rst_operands", 32'(bus.o_operands), 32'h0);
    check("rst_operation", 32'(bus.o_operation), 32'h0);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_loaded", 32'(bus.o_loaded), 32'h0);
    i_reset = 1'b0;
    cyc(3);
    bus.i_buttons = '0;
    cyc(10);
    check("post_rst_loaded", 32'(bus.o_loaded), 32'h0);
    check("post_rst_operands", 32'(bus.o_operands), 32'h0);

    // 2. debounce
    bus.i_switches = 8'h5A;
    bus.i_buttons  = 3'b001;
    cyc(3);
    bus.i_buttons  = '0;
    cyc(10);
    check("glitch_loaded", 32'(bus.o_loaded), 32'h0);
    bus.i_buttons = 3'b001;
    cyc(6);
    check("deb_early_op0", 32'(bus.o_operands), 32'h0);
    check("deb_early_loaded", 32'(bus.o_loaded), 32'h0);
    cyc(1);
    check("deb_cap_op0", 32'(bus.o_operands), 32'h005A);
    check("deb_cap_loaded", 32'(bus.o_loaded), 32'h1);
    bus.i_switches = 8'h11;
    cyc(5);
    check("deb_once_op0", 32'(bus.o_operands), 32'h005A);
    release_btn();

    // 3. direct handshake
    press(3'b001, 8'h12);
    release_btn();
    press(3'b010, 8'h34);
    check("dir_operands", 32'(bus.o_operands), 32'h3412);
    check("dir_loaded2", 32'(bus.o_loaded), 32'h3);
    check("dir_valid_lo", 32'(bus.o_valid), 32'h0);
    release_btn();
    press(3'b100, 8'hE5);
    check("dir_opcode", 32'(bus.o_operation), 32'h25);
    check("dir_loaded3", 32'(bus.o_loaded), 32'h7);
    check("dir_valid_lag", 32'(bus.o_valid), 32'h0);
    cyc(1);
    check("dir_valid_hi", 32'(bus.o_valid), 32'h1);
    release_btn();
    press(3'b001, 8'hFF);
    check("hold_operands", 32'(bus.o_operands), 32'h3412);
    check("hold_valid", 32'(bus.o_valid), 32'h1);
    release_btn();
    bus.i_ready = 1'b1;
    cyc(1);
    bus.i_ready = 1'b0;
    check("xfer_valid", 32'(bus.o_valid), 32'h0);
    check("xfer_loaded", 32'(bus.o_loaded), 32'h0);
    check("xfer_operands", 32'(bus.o_operands), 32'h3412);

    // 4. sequential
    bus.i_mode = 1'b1;
    cyc(2);
    check("seq_start_loaded", 32'(bus.o_loaded), 32'h0);
    press(3'b001, 8'h01);
    check("seq1_operands", 32'(bus.o_operands), 32'h3401);
    check("seq1_loaded", 32'(bus.o_loaded), 32'h1);
    release_btn();
    press(3'b010, 8'h99);
    check("seq_b1_ignored", 32'(bus.o_operands), 32'h3401);
    check("seq_b1_loaded", 32'(bus.o_loaded), 32'h1);
    release_btn();
    press(3'b001, 8'h02);
    check("seq2_operands", 32'(bus.o_operands), 32'h0201);
    check("seq2_loaded", 32'(bus.o_loaded), 32'h3);
    release_btn();
    press(3'b010, 8'h88);
    release_btn();
    check("seq_b1_ignored2", 32'(bus.o_operands), 32'h0201);
    press(3'b001, 8'h03);
    check("seq3_opcode", 32'(bus.o_operation), 32'h03);
    check("seq3_loaded", 32'(bus.o_loaded), 32'h7);
    cyc(1);
    check("seq_valid", 32'(bus.o_valid), 32'h1);
    release_btn();
    bus.i_ready = 1'b1;
    cyc(1);
    bus.i_ready = 1'b0;
    check("seq_xfer_valid", 32'(bus.o_valid), 32'h0);
    check("seq_xfer_loaded", 32'(bus.o_loaded), 32'h0);

    // 5. mode switch, then reset mid-debounce
    press(3'b001, 8'h44);
    check("ms_operands", 32'(bus.o_operands), 32'h0244);
    check("ms_loaded", 32'(bus.o_loaded), 32'h1);
    release_btn();
    bus.i_mode = 1'b0;
    cyc(1);
    check("ms_cleared", 32'(bus.o_loaded), 32'h0);
    press(3'b010, 8'h66);
    check("ms_direct_op1", 32'(bus.o_operands), 32'h6644);
    check("ms_direct_loaded", 32'(bus.o_loaded), 32'h2);
    release_btn();
    bus.i_switches = 8'hAA;
    bus.i_buttons  = 3'b001;
    cyc(3);
    i_reset       = 1'b1;
    bus.i_buttons = '0;
    cyc(1);
    i_reset = 1'b0;
    cyc(10);
    check("midrst_loaded", 32'(bus.o_loaded), 32'h0);
    check("midrst_operands", 32'(bus.o_operands), 32'h0);
    check("midrst_operation", 32'(bus.o_operation), 32'h0);

    // 6. simultaneous
    press(3'b011, 8'h77);
    check("sim_operands", 32'(bus.o_operands), 32'h7777);
    check("sim_loaded", 32'(bus.o_loaded), 32'h3);
    check("sim_valid_lo", 32'(bus.o_valid), 32'h0);
    release_btn();
    check("sim_valid_still_lo", 32'(bus.o_valid), 32'h0);
    press(3'b100, 8'h0A);
    check("sim_opcode", 32'(bus.o_operation), 32'h0A);
    check("sim_valid_lag", 32'(bus.o_valid), 32'h0);
    cyc(1);
    check("sim_valid_hi", 32'(bus.o_valid), 32'h1);
    release_btn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
